// File: rtl/aes_sbox_pipe.sv
// aes_sbox_pipe
//   Pipelined AES SubBytes over NUM_WORDS 32-bit words (4*NUM_WORDS byte lanes).
//   The lookup is combinational in front of stage 1; stages 2..STAGES only delay.
//   Valid/ready handshake on both sides, with bubble collapsing.
//   An opaque tag travels with each transaction.
//
// Optional feature macro: AES_SBOX_INV_EN
//   When defined, adds the in_inv port and the inverse S-box table. The mode is
//   selected per transaction. When undefined, the build is forward-only.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous, active-high reset
//   in_valid   in   input transaction present
//   in_ready   out  input accepted this cycle (forced low during reset)
//   in_data    in   32*NUM_WORDS bits, byte k = in_data[8k+7:8k]
//   in_tag     in   TAG_W-bit tag, returned unchanged
//   in_inv     in   0 = forward, 1 = inverse (AES_SBOX_INV_EN only)
//   out_valid  out  result present
//   out_ready  in   downstream accepts the result
//   out_data   out  substituted bytes, same lane order as in_data
//   out_tag    out  tag of the result
//   occupancy  out  number of transactions held in the pipeline (0..STAGES)
module aes_sbox_pipe #(
    parameter int NUM_WORDS = 2,
    parameter int STAGES    = 2,
    parameter int TAG_W     = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [32*NUM_WORDS-1:0]  in_data,
    input  logic [TAG_W-1:0]         in_tag,
`ifdef AES_SBOX_INV_EN
    input  logic                     in_inv,
`endif
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [32*NUM_WORDS-1:0]  out_data,
    output logic [TAG_W-1:0]         out_tag,
    output logic [2:0]               occupancy
);
    localparam int DW = 32 * NUM_WORDS;
    localparam int NB = 4 * NUM_WORDS;

    // Each case item holds one 16-byte row of the table, selected by the high
    // nibble. The low nibble then picks the byte, leftmost byte first.
    function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
        logic [127:0] row;
        row = '0;
        case (x[7:4])
            4'h0: row = 128'h637c777bf26b6fc53001672bfed7ab76;
            4'h1: row = 128'hca82c97dfa5947f0add4a2af9ca472c0;
            4'h2: row = 128'hb7fd9326363ff7cc34a5e5f171d83115;
            4'h3: row = 128'h04c723c31896059a071280e2eb27b275;
            4'h4: row = 128'h09832c1a1b6e5aa0523bd6b329e32f84;
            4'h5: row = 128'h53d100ed20fcb15b6acbbe394a4c58cf;
            4'h6: row = 128'hd0efaafb434d338545f9027f503c9fa8;
            4'h7: row = 128'h51a3408f929d38f5bcb6da2110fff3d2;
            4'h8: row = 128'hcd0c13ec5f974417c4a77e3d645d1973;
            4'h9: row = 128'h60814fdc222a908846eeb814de5e0bdb;
            4'ha: row = 128'he0323a0a4906245cc2d3ac629195e479;
            4'hb: row = 128'he7c8376d8dd54ea96c56f4ea657aae08;
            4'hc: row = 128'hba78252e1ca6b4c6e8dd741f4bbd8b8a;
            4'hd: row = 128'h703eb5664803f60e613557b986c11d9e;
            4'he: row = 128'he1f8981169d98e949b1e87e9ce5528df;
            4'hf: row = 128'h8ca1890dbfe6426841992d0fb054bb16;
        endcase
        return row[{~x[3:0], 3'b000} +: 8];
    endfunction

`ifdef AES_SBOX_INV_EN
    function automatic logic [7:0] sbox_inv(input logic [7:0] x);
        logic [127:0] row;
        row = '0;
        case (x[7:4])
            4'h0: row = 128'h52096ad53036a538bf40a39e81f3d7fb;
            4'h1: row = 128'h7ce339829b2fff87348e4344c4dee9cb;
            4'h2: row = 128'h547b9432a6c2233dee4c950b42fac34e;
            4'h3: row = 128'h082ea16628d924b2765ba2496d8bd125;
            4'h4: row = 128'h72f8f66486689816d4a45ccc5d65b692;
            4'h5: row = 128'h6c704850fdedb9da5e154657a78d9d84;
            4'h6: row = 128'h90d8ab008cbcd30af7e45805b8b34506;
            4'h7: row = 128'hd02c1e8fca3f0f02c1afbd0301138a6b;
            4'h8: row = 128'h3a9111414f67dcea97f2cfcef0b4e673;
            4'h9: row = 128'h96ac7422e7ad3585e2f937e81c75df6e;
            4'ha: row = 128'h47f11a711d29c5896fb7620eaa18be1b;
            4'hb: row = 128'hfc563e4bc6d279209adbc0fe78cd5af4;
            4'hc: row = 128'h1fdda8338807c731b11210592780ec5f;
            4'hd: row = 128'h60517fa919b54a0d2de57a9f93c99cef;
            4'he: row = 128'ha0e03b4dae2af5b0c8ebbb3c83539961;
            4'hf: row = 128'h172b047eba77d626e169146355210c7d;
        endcase
        return row[{~x[3:0], 3'b000} +: 8];
    endfunction
`endif

    logic [DW-1:0]     sub_d;
    logic [DW-1:0]     data_q [STAGES];
    logic [TAG_W-1:0]  tag_q  [STAGES];
    logic [STAGES-1:0] vld_q;
    logic [2:0]        occ_q;

    logic [STAGES-1:0] rdy;
    logic [STAGES-1:0] src_vld;
    logic [DW-1:0]     src_data [STAGES];
    logic [TAG_W-1:0]  src_tag  [STAGES];
    logic              in_fire;
    logic              out_fire;

    // ---- stage 0 -> 1 boundary: combinational substitution of every lane ----
    always_comb begin
        sub_d = '0;
        for (int k = 0; k < NB; k++) begin
`ifdef AES_SBOX_INV_EN
            sub_d[8*k +: 8] = in_inv ? sbox_inv(in_data[8*k +: 8])
                                     : sbox_fwd(in_data[8*k +: 8]);
`else
            sub_d[8*k +: 8] = sbox_fwd(in_data[8*k +: 8]);
`endif
        end
    end

    // Stage i may load when the output is draining or any stage from i to the
    // end holds a bubble. This collapses bubbles without a ripple through rdy.
    always_comb begin
        rdy = '0;
        for (int i = 0; i < STAGES; i++) begin
            rdy[i] = out_ready;
            for (int j = i; j < STAGES; j++) begin
                if (!vld_q[j]) rdy[i] = 1'b1;
            end
        end
    end

    always_comb begin
        src_vld     = '0;
        src_vld[0]  = in_valid;
        src_data[0] = sub_d;
        src_tag[0]  = in_tag;
        for (int i = 1; i < STAGES; i++) begin
            src_vld[i]  = vld_q[i-1];
            src_data[i] = data_q[i-1];
            src_tag[i]  = tag_q[i-1];
        end
    end

    assign in_ready  = !reset && rdy[0];
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    // ---- stage registers 1..STAGES ----
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= '0;
            occ_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                if (rdy[i]) begin
                    vld_q[i] <= src_vld[i];
                    if (src_vld[i]) begin
                        data_q[i] <= src_data[i];
                        tag_q[i]  <= src_tag[i];
                    end
                end
            end
            case ({in_fire, out_fire})
                2'b10:   occ_q <= occ_q + 3'd1;
                2'b01:   occ_q <= occ_q - 3'd1;
                default: occ_q <= occ_q;
            endcase
        end
    end

    // ---- stage STAGES -> output boundary ----
    assign out_valid = vld_q[STAGES-1];
    assign out_data  = data_q[STAGES-1];
    assign out_tag   = tag_q[STAGES-1];
    assign occupancy = occ_q;

endmodule

// File: tb/tb_aes_sbox_pipe.sv
module tb_aes_sbox_pipe;
    localparam int NW = 2;
    localparam int TW = 4;
    localparam int DW = 32 * NW;
    localparam int ND = 3;  // instance 0: STAGES=2, 1: STAGES=1, 2: STAGES=4

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic [ND-1:0]          in_valid;
    logic [ND-1:0]          in_ready;
    logic [ND-1:0][DW-1:0]  in_data;
    logic [ND-1:0][TW-1:0]  in_tag;
    logic [ND-1:0]          inv_sel;
    logic [ND-1:0]          out_valid;
    logic [ND-1:0]          out_ready;
    logic [ND-1:0][DW-1:0]  out_data;
    logic [ND-1:0][TW-1:0]  out_tag;
    logic [ND-1:0][2:0]     occupancy;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] fwd_tab [256];
    logic [7:0] inv_tab [256];

    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        aes_sbox_pipe #(
            .NUM_WORDS(NW),
            .STAGES(g == 0 ? 2 : (g == 1 ? 1 : 4)),
            .TAG_W(TW)
        ) u_dut (
            .clk(clk),
            .reset(reset),
            .in_valid(in_valid[g]),
            .in_ready(in_ready[g]),
            .in_data(in_data[g]),
            .in_tag(in_tag[g]),
`ifdef AES_SBOX_INV_EN
            .in_inv(inv_sel[g]),
`endif
            .out_valid(out_valid[g]),
            .out_ready(out_ready[g]),
            .out_data(out_data[g]),
            .out_tag(out_tag[g]),
            .occupancy(occupancy[g])
        );
    end

    function automatic int stages_of(input int d);
        return (d == 0) ? 2 : ((d == 1) ? 1 : 4);
    endfunction

    // Reference model: S-box built from GF(2^8) inversion plus the affine map.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
            bb = {1'b0, bb[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] model_sbox(input logic [7:0] x);
        logic [7:0] b;
        logic [7:0] r1, r2, r3, r4;
        b = 8'h01;
        for (int i = 0; i < 254; i++) b = gmul(b, x);  // x^254 = x^-1, 0 -> 0
        r1 = {b[6:0], b[7]};
        r2 = {r1[6:0], r1[7]};
        r3 = {r2[6:0], r2[7]};
        r4 = {r3[6:0], r3[7]};
        return b ^ r1 ^ r2 ^ r3 ^ r4 ^ 8'h63;
    endfunction

    task automatic init_model();
        logic [7:0] v;
        for (int i = 0; i < 256; i++) begin
            v = model_sbox(i[7:0]);
            fwd_tab[i] = v;
            inv_tab[v] = i[7:0];
        end
    endtask

    function automatic logic [DW-1:0] model_word(input logic [DW-1:0] w, input logic inv);
        logic [DW-1:0] r;
        r = '0;
        for (int k = 0; k < DW / 8; k++)
            r[8*k +: 8] = inv ? inv_tab[w[8*k +: 8]] : fwd_tab[w[8*k +: 8]];
        return r;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        for (int d = 0; d < ND; d++) begin
            n_checks++;
            if (in_ready[d] !== 1'b0) $display("FAIL reset_in_ready[%0d]: got %b want 0", d, in_ready[d]);
            else n_pass++;
            n_checks++;
            if (out_valid[d] !== 1'b0) $display("FAIL reset_out_valid[%0d]: got %b want 0", d, out_valid[d]);
            else n_pass++;
            n_checks++;
            if (occupancy[d] !== 3'd0) $display("FAIL reset_occupancy[%0d]: got %0d want 0", d, occupancy[d]);
            else n_pass++;
            n_checks++;
            if (out_data[d] !== '0 || out_tag[d] !== '0)
                $display("FAIL reset_out_data[%0d]: got %h/%h want 0/0", d, out_data[d], out_tag[d]);
            else n_pass++;
        end
        reset = 1'b0;
        #1;
        for (int d = 0; d < ND; d++) begin
            n_checks++;
            if (in_ready[d] !== 1'b1) $display("FAIL release_in_ready[%0d]: got %b want 1", d, in_ready[d]);
            else n_pass++;
        end
    endtask

    task automatic test_vector();
        @(negedge clk);
        in_valid[0] = 1'b1; in_data[0] = 64'h00010253_ff000000; in_tag[0] = 4'h5;
        inv_sel[0] = 1'b0; out_ready[0] = 1'b1;
        #1;
        n_checks++;
        if (in_ready[0] !== 1'b1) $display("FAIL vec_in_ready: got %b want 1", in_ready[0]);
        else n_pass++;
        @(negedge clk);
        in_valid[0] = 1'b0;
        #1;
        n_checks++;
        if (out_valid[0] !== 1'b0) $display("FAIL vec_early_valid: got %b want 0", out_valid[0]);
        else n_pass++;
        @(negedge clk);
        #1;
        n_checks++;
        if (out_valid[0] !== 1'b1 || out_data[0] !== 64'h637c77ed_16636363 || out_tag[0] !== 4'h5)
            $display("FAIL vec_result: got v=%b %h tag %h want v=1 637c77ed16636363 tag 5",
                     out_valid[0], out_data[0], out_tag[0]);
        else n_pass++;
        @(negedge clk);
        #1;
        n_checks++;
        if (out_valid[0] !== 1'b0) $display("FAIL vec_drained: got %b want 0", out_valid[0]);
        else n_pass++;
    endtask

    task automatic test_streaming();
        logic [DW-1:0] sd [256];
        logic [TW-1:0] st [256];
        logic [DW-1:0] w;
        logic          exp_v;
        for (int c = 0; c < 260; c++) begin
            @(negedge clk);
            out_ready[0] = 1'b1;
            inv_sel[0]   = 1'b0;
            if (c < 256) begin
                w = {$urandom, $urandom};
                w[7:0] = c[7:0];
                sd[c] = w; st[c] = c[TW-1:0];
                in_valid[0] = 1'b1; in_data[0] = w; in_tag[0] = c[TW-1:0];
            end else begin
                in_valid[0] = 1'b0;
            end
            #1;
            if (c < 256) begin
                n_checks++;
                if (in_ready[0] !== 1'b1) $display("FAIL stream_in_ready c=%0d: got %b want 1", c, in_ready[0]);
                else n_pass++;
            end
            exp_v = (c >= 2 && c < 258);
            n_checks++;
            if (out_valid[0] !== exp_v) $display("FAIL stream_out_valid c=%0d: got %b want %b", c, out_valid[0], exp_v);
            else n_pass++;
            if (exp_v) begin
                n_checks++;
                if (out_data[0] !== model_word(sd[c-2], 1'b0) || out_tag[0] !== st[c-2])
                    $display("FAIL stream_data c=%0d: got %h/%h want %h/%h", c, out_data[0], out_tag[0],
                             model_word(sd[c-2], 1'b0), st[c-2]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] a, b, c;
        a = {$urandom, $urandom}; b = {$urandom, $urandom}; c = {$urandom, $urandom};
        @(negedge clk);
        out_ready[0] = 1'b0; inv_sel[0] = 1'b0;
        in_valid[0] = 1'b1; in_data[0] = a; in_tag[0] = 4'h1;
        #1;
        n_checks++;
        if (in_ready[0] !== 1'b1) $display("FAIL bp_accept_a: got %b want 1", in_ready[0]);
        else n_pass++;
        @(negedge clk);
        in_data[0] = b; in_tag[0] = 4'h2;
        #1;
        n_checks++;
        if (in_ready[0] !== 1'b1) $display("FAIL bp_accept_b: got %b want 1", in_ready[0]);
        else n_pass++;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            in_data[0] = c; in_tag[0] = 4'h3;
            #1;
            n_checks++;
            if (in_ready[0] !== 1'b0 || occupancy[0] !== 3'd2)
                $display("FAIL bp_full k=%0d: got ready=%b occ=%0d want ready=0 occ=2", k, in_ready[0], occupancy[0]);
            else n_pass++;
            n_checks++;
            if (out_valid[0] !== 1'b1 || out_data[0] !== model_word(a, 1'b0) || out_tag[0] !== 4'h1)
                $display("FAIL bp_hold k=%0d: got v=%b %h/%h want v=1 %h/1", k, out_valid[0], out_data[0],
                         out_tag[0], model_word(a, 1'b0));
            else n_pass++;
        end
        @(negedge clk);
        out_ready[0] = 1'b1;
        #1;
        n_checks++;
        if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b1 || out_data[0] !== model_word(a, 1'b0))
            $display("FAIL bp_release: got ready=%b v=%b %h want ready=1 v=1 %h", in_ready[0], out_valid[0],
                     out_data[0], model_word(a, 1'b0));
        else n_pass++;
        @(negedge clk);
        in_valid[0] = 1'b0;
        #1;
        n_checks++;
        if (out_valid[0] !== 1'b1 || out_data[0] !== model_word(b, 1'b0) || out_tag[0] !== 4'h2 || occupancy[0] !== 3'd2)
            $display("FAIL bp_second: got v=%b %h/%h occ=%0d want v=1 %h/2 occ=2", out_valid[0], out_data[0],
                     out_tag[0], occupancy[0], model_word(b, 1'b0));
        else n_pass++;
        @(negedge clk);
        #1;
        n_checks++;
        if (out_valid[0] !== 1'b1 || out_data[0] !== model_word(c, 1'b0) || out_tag[0] !== 4'h3 || occupancy[0] !== 3'd1)
            $display("FAIL bp_third: got v=%b %h/%h occ=%0d want v=1 %h/3 occ=1", out_valid[0], out_data[0],
                     out_tag[0], occupancy[0], model_word(c, 1'b0));
        else n_pass++;
        @(negedge clk);
        #1;
        n_checks++;
        if (out_valid[0] !== 1'b0 || occupancy[0] !== 3'd0)
            $display("FAIL bp_empty: got v=%b occ=%0d want v=0 occ=0", out_valid[0], occupancy[0]);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        out_ready[0] = 1'b0; in_valid[0] = 1'b1; in_data[0] = {$urandom, $urandom}; in_tag[0] = 4'h7;
        @(negedge clk);
        in_data[0] = {$urandom, $urandom}; in_tag[0] = 4'h8;
        @(negedge clk);
        in_valid[0] = 1'b0;
        #1;
        n_checks++;
        if (occupancy[0] !== 3'd2) $display("FAIL rstmid_filled: got occ=%0d want 2", occupancy[0]);
        else n_pass++;
        reset = 1'b1;
        @(negedge clk);
        #1;
        n_checks++;
        if (out_valid[0] !== 1'b0 || occupancy[0] !== 3'd0 || in_ready[0] !== 1'b0)
            $display("FAIL rstmid_cleared: got v=%b occ=%0d ready=%b want 0/0/0", out_valid[0], occupancy[0], in_ready[0]);
        else n_pass++;
        reset = 1'b0;
        out_ready[0] = 1'b1;
        #1;
        n_checks++;
        if (in_ready[0] !== 1'b1) $display("FAIL rstmid_ready: got %b want 1", in_ready[0]);
        else n_pass++;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            #1;
            n_checks++;
            if (out_valid[0] !== 1'b0 || occupancy[0] !== 3'd0)
                $display("FAIL rstmid_stale k=%0d: got v=%b occ=%0d want 0/0", k, out_valid[0], occupancy[0]);
            else n_pass++;
        end
    endtask

    task automatic test_latency(input int d);
        logic [DW-1:0] w;
        int lat;
        w = {$urandom, $urandom};
        lat = 0;
        @(negedge clk);
        out_ready[d] = 1'b1; inv_sel[d] = 1'b0;
        in_valid[d] = 1'b1; in_data[d] = w; in_tag[d] = 4'ha;
        #1;
        n_checks++;
        if (in_ready[d] !== 1'b1) $display("FAIL lat_in_ready[%0d]: got %b want 1", d, in_ready[d]);
        else n_pass++;
        for (int k = 1; k <= 10 && lat == 0; k++) begin
            @(negedge clk);
            in_valid[d] = 1'b0;
            #1;
            if (out_valid[d] === 1'b1) begin
                lat = k;
                n_checks++;
                if (out_data[d] !== model_word(w, 1'b0) || out_tag[d] !== 4'ha)
                    $display("FAIL lat_data[%0d]: got %h/%h want %h/a", d, out_data[d], out_tag[d], model_word(w, 1'b0));
                else n_pass++;
            end
        end
        n_checks++;
        if (lat != stages_of(d)) $display("FAIL latency[%0d]: got %0d want %0d (0 = none)", d, lat, stages_of(d));
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_random_sweep(input int d, input int n_txn);
        logic [DW+TW-1:0] exp_q [$];
        logic [DW+TW-1:0] exp_e;
        logic [DW-1:0]    hold_data;
        logic [TW-1:0]    hold_tag;
        logic [DW-1:0]    w;
        logic [31:0]      r;
        logic [31:0]      qsz;
        bit               hold_pending;
        bit               fired;
        int               sent, got, cyc;
        hold_pending = 0; fired = 0; sent = 0; got = 0; cyc = 0;
        hold_data = '0; hold_tag = '0;
        in_valid[d] = 1'b0;
        while ((sent < n_txn || got < sent) && cyc < 6000) begin
            @(negedge clk);
            cyc++;
            if (fired) in_valid[d] = 1'b0;
            if (!in_valid[d] && sent < n_txn && $urandom_range(0, 3) != 0) begin
                w = {$urandom, $urandom};
                r = $urandom;
                in_valid[d] = 1'b1; in_data[d] = w; in_tag[d] = r[TW-1:0];
`ifdef AES_SBOX_INV_EN
                inv_sel[d] = r[8];
`else
                inv_sel[d] = 1'b0;
`endif
            end
            out_ready[d] = ($urandom_range(0, 3) != 0);
            #1;
            if (hold_pending) begin
                n_checks++;
                if (out_valid[d] !== 1'b1 || out_data[d] !== hold_data || out_tag[d] !== hold_tag)
                    $display("FAIL sweep_stable[%0d] cyc=%0d: got v=%b %h/%h want v=1 %h/%h", d, cyc,
                             out_valid[d], out_data[d], out_tag[d], hold_data, hold_tag);
                else n_pass++;
            end
            qsz = exp_q.size();
            n_checks++;
            if (occupancy[d] !== qsz[2:0])
                $display("FAIL sweep_occupancy[%0d] cyc=%0d: got %0d want %0d", d, cyc, occupancy[d], qsz);
            else n_pass++;
            if (out_valid[d] === 1'b1 && out_ready[d] === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL sweep_spurious[%0d] cyc=%0d: got output %h with nothing outstanding", d, cyc, out_data[d]);
                end else begin
                    exp_e = exp_q.pop_front();
                    if ({out_data[d], out_tag[d]} !== exp_e)
                        $display("FAIL sweep_data[%0d] cyc=%0d: got %h/%h want %h/%h", d, cyc, out_data[d],
                                 out_tag[d], exp_e[DW+TW-1:TW], exp_e[TW-1:0]);
                    else n_pass++;
                end
                got++;
            end
            hold_pending = (out_valid[d] === 1'b1) && (out_ready[d] === 1'b0);
            hold_data = out_data[d];
            hold_tag  = out_tag[d];
            fired = (in_valid[d] === 1'b1) && (in_ready[d] === 1'b1);
            if (fired) begin
                exp_q.push_back({model_word(in_data[d], inv_sel[d]), in_tag[d]});
                sent++;
            end
        end
        in_valid[d] = 1'b0;
        out_ready[d] = 1'b1;
        n_checks++;
        if (sent != n_txn || got != sent)
            $display("FAIL sweep_complete[%0d]: got sent=%0d received=%0d want %0d/%0d", d, sent, got, n_txn, n_txn);
        else n_pass++;
        @(negedge clk);
        #1;
        n_checks++;
        if (out_valid[d] !== 1'b0 || occupancy[d] !== 3'd0)
            $display("FAIL sweep_drained[%0d]: got v=%b occ=%0d want 0/0", d, out_valid[d], occupancy[d]);
        else n_pass++;
    endtask

`ifdef AES_SBOX_INV_EN
    task automatic test_inv_interleave();
        logic [DW-1:0] sd [16];
        logic [TW-1:0] st [16];
        logic          si [16];
        logic [DW-1:0] w;
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            out_ready[0] = 1'b1;
            if (c < 16) begin
                w = (c < 4) ? {32'h637c1600, 32'h637c1600} : {$urandom, $urandom};
                sd[c] = w; st[c] = c[TW-1:0]; si[c] = c[0];
                in_valid[0] = 1'b1; in_data[0] = w; in_tag[0] = c[TW-1:0]; inv_sel[0] = c[0];
            end else begin
                in_valid[0] = 1'b0;
            end
            #1;
            if (c >= 2) begin
                n_checks++;
                if (out_valid[0] !== 1'b1 || out_data[0] !== model_word(sd[c-2], si[c-2]) || out_tag[0] !== st[c-2])
                    $display("FAIL inv_mix c=%0d: got v=%b %h/%h want v=1 %h/%h", c, out_valid[0], out_data[0],
                             out_tag[0], model_word(sd[c-2], si[c-2]), st[c-2]);
                else n_pass++;
            end
            if (c == 2) begin
                n_checks++;
                if (out_data[0] !== 64'hfb104763_fb104763) $display("FAIL inv_fwd_word: got %h want fb104763fb104763", out_data[0]);
                else n_pass++;
            end
            if (c == 3) begin
                n_checks++;
                if (out_data[0] !== 64'h0001ff52_0001ff52) $display("FAIL inv_inv_word: got %h want 0001ff520001ff52", out_data[0]);
                else n_pass++;
            end
        end
        inv_sel[0] = 1'b0;
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, got no completion want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        in_valid  = '0;
        in_data   = '0;
        in_tag    = '0;
        inv_sel   = '0;
        out_ready = '1;
        init_model();
        test_reset();
        test_vector();
        test_streaming();
        test_backpressure();
        test_reset_mid();
        for (int d = 0; d < ND; d++) test_latency(d);
        for (int d = 0; d < ND; d++) test_random_sweep(d, 300);
`ifdef AES_SBOX_INV_EN
        test_inv_interleave();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
